nabp_processing_bank_sequencer: RTL and testbench

NABP_PROCESSING_BANK_SEQUENCER -- requirements
Module: nabp_processing_bank_sequencer

---
 rtl/nabp_pkg.sv | 21 ++
 rtl/nabp_tap_chain.sv | 24 ++
 rtl/nabp_processing_bank_sequencer.sv | 131 +++++++++++++
 tb/tb_nabp_processing_bank_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nabp_pkg.sv
// Shared definitions for the NABP processing-bank sequencer: FSM encoding and a width helper.
package nabp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StScan,
    StDrain,
    StRotate,
    StDone
  } state_e;

  // Bits needed to index n items; never returns 0 so one-item indices still have a width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/nabp_tap_chain.sv
// Shift register feeding the PE tap lanes: new sample enters lane 0, last lane falls off.
module nabp_tap_chain #(
  parameter int unsigned pNoOfPartitions = 4,
  parameter int unsigned pDataLength     = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   shift,
  input  logic [pDataLength-1:0]                 din,
  output logic [pNoOfPartitions*pDataLength-1:0] taps
);

  localparam int unsigned TapW = pNoOfPartitions * pDataLength;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      taps <= '0;
    end else if (shift) begin
      taps <= {taps[TapW-pDataLength-1:0], din};
    end
  end

endmodule

// File: rtl/nabp_processing_bank_sequencer.sv
// Walks each projection angle through a filtered-RAM bank, streaming lines into the PE tap chain.
module nabp_processing_bank_sequencer
  import nabp_pkg::*;
#(
  parameter int unsigned pNoOfBanks      = 2,
  parameter int unsigned pNoOfPartitions = 4,
  parameter int unsigned pPartitionSize  = 16,
  parameter int unsigned pDataLength     = 16,
  parameter int unsigned pAngleLength    = 12,
  parameter int unsigned pSLength        = 10,
  parameter int unsigned pBidirectional  = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [pAngleLength-1:0]                fr_angle,
  input  logic                                   fr_has_next_angle,
  output logic                                   fr_next_angle,
  input  logic                                   fr_next_angle_ack,
  input  logic [pNoOfBanks*pDataLength-1:0]      fr_val,
  output logic [pSLength-1:0]                    fr_s_val,
  output logic [clog2(pNoOfBanks)-1:0]           fr_bank,
  output logic                                   pe_reset,
  output logic                                   pe_en,
  output logic                                   pe_scan_direction,
  output logic [pNoOfPartitions*pDataLength-1:0] pe_taps,
  output logic                                   done,
  output logic [pAngleLength-1:0]                db_angle,
  output logic [clog2(pPartitionSize)-1:0]       db_line_itr
);

  localparam int unsigned BankW = clog2(pNoOfBanks);
  localparam int unsigned LineW = clog2(pPartitionSize);
  localparam logic [LineW-1:0] LastLine = LineW'(pPartitionSize - 1);
  localparam logic [BankW-1:0] LastBank = BankW'(pNoOfBanks - 1);

  state_e                 state_q;
  logic [LineW-1:0]       first_line, end_line, next_line;
  logic [pDataLength-1:0] bank_data;
  logic                   ack_accept;

  always_comb begin
    first_line = pe_scan_direction ? LastLine : '0;
    end_line   = pe_scan_direction ? '0 : LastLine;
    next_line  = pe_scan_direction ? db_line_itr - 1'b1 : db_line_itr + 1'b1;
  end

  always_comb begin
    bank_data = '0;
    for (int b = 0; b < int'(pNoOfBanks); b++) begin
      if (fr_bank == BankW'(b)) bank_data = fr_val[b*pDataLength +: pDataLength];
    end
  end

  // An ack only counts once the request has been visible on fr_next_angle.
  assign ack_accept = (state_q == StReq) && fr_next_angle && fr_next_angle_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StIdle;
      fr_next_angle     <= 1'b0;
      fr_s_val          <= '0;
      fr_bank           <= '0;
      pe_reset          <= 1'b0;
      pe_en             <= 1'b0;
      pe_scan_direction <= 1'b0;
      done              <= 1'b0;
      db_angle          <= '0;
      db_line_itr       <= '0;
    end else begin
      pe_reset <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (!fr_next_angle) begin
            if (fr_has_next_angle) begin
              fr_next_angle <= 1'b1;
            end else begin
              state_q           <= StDone;
              done              <= 1'b1;
              fr_bank           <= '0;
              fr_s_val          <= '0;
              pe_scan_direction <= 1'b0;
              db_line_itr       <= '0;
            end
          end else if (ack_accept) begin
            fr_next_angle <= 1'b0;
            db_angle      <= fr_angle;
            pe_reset      <= 1'b1;
            db_line_itr   <= first_line;
            fr_s_val      <= pSLength'(first_line);
            state_q       <= StScan;
          end
        end
        StScan: begin
          // Read data lags the address by one cycle, so pe_en trails the scan by one.
          pe_en <= 1'b1;
          if (db_line_itr == end_line) begin
            state_q <= StDrain;
          end else begin
            db_line_itr <= next_line;
            fr_s_val    <= pSLength'(next_line);
          end
        end
        StDrain: begin
          pe_en   <= 1'b0;
          state_q <= StRotate;
        end
        StRotate: begin
          fr_bank <= (fr_bank == LastBank) ? '0 : fr_bank + 1'b1;
          if (pBidirectional != 0) pe_scan_direction <= ~pe_scan_direction;
          state_q <= StReq;
        end
        StDone: done <= 1'b1;
        default: state_q <= StIdle;
      endcase
    end
  end

  nabp_tap_chain #(
    .pNoOfPartitions(pNoOfPartitions),
    .pDataLength    (pDataLength)
  ) u_tap_chain (
    .clk  (clk),
    .reset(reset),
    .clear(ack_accept),
    .shift(pe_en),
    .din  (bank_data),
    .taps (pe_taps)
  );

endmodule

// File: tb/tb_nabp_processing_bank_sequencer.sv
// Directed bench: default sequencer (dut0) and a 3-bank bidirectional sequencer (dut1).
module tb_nabp_processing_bank_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], has_next[2], ack[2];
  logic [11:0] ang[2];
  logic [47:0] val[2];
  logic        nreq[2], pe_reset[2], pe_en[2], dir[2], done[2];
  logic [9:0]  sval[2];
  logic        bank0;
  logic [1:0]  bank1;
  logic [63:0] taps[2];
  logic [11:0] dbang[2];
  logic [3:0]  itr[2];

  int checks = 0;
  int passes = 0;

  nabp_processing_bank_sequencer dut0 (
    .clk(clk), .reset(rst[0]), .fr_angle(ang[0]), .fr_has_next_angle(has_next[0]),
    .fr_next_angle(nreq[0]), .fr_next_angle_ack(ack[0]), .fr_val(val[0][31:0]),
    .fr_s_val(sval[0]), .fr_bank(bank0), .pe_reset(pe_reset[0]), .pe_en(pe_en[0]),
    .pe_scan_direction(dir[0]), .pe_taps(taps[0]), .done(done[0]), .db_angle(dbang[0]),
    .db_line_itr(itr[0])
  );

  nabp_processing_bank_sequencer #(.pNoOfBanks(3), .pBidirectional(1)) dut1 (
    .clk(clk), .reset(rst[1]), .fr_angle(ang[1]), .fr_has_next_angle(has_next[1]),
    .fr_next_angle(nreq[1]), .fr_next_angle_ack(ack[1]), .fr_val(val[1]),
    .fr_s_val(sval[1]), .fr_bank(bank1), .pe_reset(pe_reset[1]), .pe_en(pe_en[1]),
    .pe_scan_direction(dir[1]), .pe_taps(taps[1]), .done(done[1]), .db_angle(dbang[1]),
    .db_line_itr(itr[1])
  );

  // Registered RAM model: bank b holds 3*s + 256*b at address s.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 3; b++) val[d][b*16 +: 16] <= 16'(int'(sval[d]) * 3 + b * 256);
    end
  end

  function automatic int bank_of(input int d);
    return (d == 0) ? int'(bank0) : int'(bank1);
  endfunction

  function automatic logic [127:0] outs(input int d);
    return 128'({nreq[d], sval[d], (d == 0) ? {1'b0, bank0} : bank1, pe_reset[d], pe_en[d],
                 dir[d], taps[d], done[d], dbang[d], itr[d]});
  endfunction

  task automatic test_reset(input int d);
    rst[d] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs(d) !== '0) $display("FAIL reset_outs: dut%0d outputs=%0h want 0", d, outs(d));
    else passes++;
    rst[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (nreq[d] !== 1'b0 || done[d] !== 1'b0)
      $display("FAIL req_entry: dut%0d fr_next_angle=%b done=%b want 0 0", d, nreq[d], done[d]);
    else passes++;
  endtask

  task automatic test_angle(input int d, input logic [11:0] a, input int delay, input int xbank,
                            input logic xdir, input bit last, input bit chk_taps);
    int n, req_cyc, wait_en, en_cnt, rst_cnt, xi;
    logic [63:0] xt;
    n = 0; req_cyc = 1; wait_en = 0; en_cnt = 0; rst_cnt = 0;
    xt = {16'd6, 16'd9, 16'd12, 16'd15};
    while (nreq[d] !== 1'b1 && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    checks++;
    if (nreq[d] !== 1'b1) begin
      $display("FAIL req_timeout: dut%0d fr_next_angle=%b want 1", d, nreq[d]);
      return;
    end
    passes++;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); @(negedge clk);
      if (nreq[d] === 1'b1) req_cyc++;
      if (pe_en[d] === 1'b1) wait_en++;
    end
    ang[d] = a;
    ack[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    ack[d] = 1'b0;
    checks++;
    if (req_cyc != delay + 1 || nreq[d] !== 1'b0)
      $display("FAIL req_len: dut%0d high %0d cycles (now %b) want %0d", d, req_cyc, nreq[d],
               delay + 1);
    else passes++;
    checks++;
    if (wait_en != 0) $display("FAIL wait_pe_en: dut%0d got %0d want 0", d, wait_en);
    else passes++;
    checks++;
    if (dbang[d] !== a) $display("FAIL db_angle: dut%0d got %0h want %0h", d, dbang[d], a);
    else passes++;
    checks++;
    if (taps[d] !== '0) $display("FAIL taps_clear: dut%0d got %0h want 0", d, taps[d]);
    else passes++;
    checks++;
    if (bank_of(d) != xbank) $display("FAIL fr_bank: dut%0d got %0d want %0d", d, bank_of(d), xbank);
    else passes++;
    checks++;
    if (dir[d] !== xdir) $display("FAIL scan_dir: dut%0d got %b want %b", d, dir[d], xdir);
    else passes++;
    for (int i = 1; i <= 16; i++) begin
      xi = xdir ? 16 - i : i - 1;
      checks++;
      if (itr[d] !== 4'(xi) || sval[d] !== 10'(xi))
        $display("FAIL line_itr: dut%0d cycle %0d itr=%0d s=%0d want %0d", d, i, itr[d], sval[d], xi);
      else passes++;
      if (pe_en[d] === 1'b1) en_cnt++;
      if (pe_reset[d] === 1'b1) rst_cnt++;
      if (chk_taps && i == 8) begin
        checks++;
        if (taps[d] !== xt) $display("FAIL taps_line5: dut%0d got %0h want %0h", d, taps[d], xt);
        else passes++;
      end
      if (i == 3) begin
        ang[d] = 12'hABC;
        ack[d] = 1'b1;
      end
      if (i == 4) ack[d] = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    if (pe_en[d] === 1'b1) en_cnt++;
    @(posedge clk); @(negedge clk);
    if (pe_en[d] === 1'b1) en_cnt++;
    has_next[d] = !last;
    checks++;
    if (en_cnt != 16) $display("FAIL pe_en_count: dut%0d got %0d want 16", d, en_cnt);
    else passes++;
    checks++;
    if (rst_cnt != 1) $display("FAIL pe_reset_count: dut%0d got %0d want 1", d, rst_cnt);
    else passes++;
    checks++;
    if (dbang[d] !== a) $display("FAIL stray_ack: dut%0d db_angle=%0h want %0h", d, dbang[d], a);
    else passes++;
  endtask

  task automatic test_done(input int d, input logic [11:0] a, input int xbank, input logic xdir);
    logic [63:0] xt;
    for (int k = 0; k < 4; k++) xt[k*16 +: 16] = 16'((xdir ? k : 15 - k) * 3 + xbank * 256);
    @(posedge clk); @(negedge clk);
    checks++;
    if (nreq[d] !== 1'b0 || done[d] !== 1'b0)
      $display("FAIL last_req: dut%0d fr_next_angle=%b done=%b want 0 0", d, nreq[d], done[d]);
    else passes++;
    @(posedge clk); @(negedge clk);
    checks++;
    if (done[d] !== 1'b1) $display("FAIL done: dut%0d got %b want 1", d, done[d]);
    else passes++;
    checks++;
    if (nreq[d] !== 1'b0 || sval[d] !== '0 || bank_of(d) != 0 || pe_reset[d] !== 1'b0 ||
        pe_en[d] !== 1'b0 || dir[d] !== 1'b0 || itr[d] !== '0)
      $display("FAIL done_outs: dut%0d outputs=%0h want zeroed", d, outs(d));
    else passes++;
    checks++;
    if (dbang[d] !== a) $display("FAIL done_angle: dut%0d got %0h want %0h", d, dbang[d], a);
    else passes++;
    checks++;
    if (taps[d] !== xt) $display("FAIL done_taps: dut%0d got %0h want %0h", d, taps[d], xt);
    else passes++;
    has_next[d] = 1'b1;
    ang[d] = 12'h777;
    ack[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    ack[d] = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (done[d] !== 1'b1 || nreq[d] !== 1'b0 || dbang[d] !== a)
      $display("FAIL done_hold: dut%0d done=%b req=%b angle=%0h want 1 0 %0h", d, done[d],
               nreq[d], dbang[d], a);
    else passes++;
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    has_next[0] = 1'b1;
    rst[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst[0] = 1'b0;
    while (nreq[0] !== 1'b1 && n < 10) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    ang[0] = 12'h5A5;
    ack[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    ack[0] = 1'b0;
    n = 0;
    while (itr[0] !== 4'd7 && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    checks++;
    if (itr[0] !== 4'd7) $display("FAIL mid_scan_reach: itr=%0d want 7", itr[0]);
    else passes++;
    rst[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (outs(0) !== '0) $display("FAIL mid_reset_outs: outputs=%0h want 0", outs(0));
    else passes++;
    rst[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (nreq[0] !== 1'b0) $display("FAIL restart_idle: fr_next_angle=%b want 0", nreq[0]);
    else passes++;
    test_angle(0, 12'h5A5, 2, 0, 1'b0, 1'b1, 1'b1);
    test_done(0, 12'h5A5, 0, 1'b0);
  endtask

  task automatic test_no_angle();
    int n_req, n_en;
    n_req = 0; n_en = 0;
    has_next[1] = 1'b0;
    rst[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst[1] = 1'b0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (nreq[1] === 1'b1) n_req++;
      if (pe_en[1] === 1'b1) n_en++;
    end
    checks++;
    if (done[1] !== 1'b1 || n_req != 0 || n_en != 0)
      $display("FAIL no_angle: done=%b req_cycles=%0d en_cycles=%0d want 1 0 0", done[1], n_req,
               n_en);
    else passes++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      has_next[d] = 1'b1;
      ack[d] = 1'b0;
      ang[d] = '0;
    end
    test_reset(0);
    test_angle(0, 12'h000, 0, 0, 1'b0, 1'b0, 1'b1);
    test_angle(0, 12'h001, 5, 1, 1'b0, 1'b0, 1'b0);
    test_angle(0, 12'h002, 1, 0, 1'b0, 1'b1, 1'b0);
    test_done(0, 12'h002, 0, 1'b0);
    test_mid_reset();
    test_reset(1);
    test_angle(1, 12'h010, 0, 0, 1'b0, 1'b0, 1'b0);
    test_angle(1, 12'h011, 1, 1, 1'b1, 1'b0, 1'b0);
    test_angle(1, 12'h012, 3, 2, 1'b0, 1'b0, 1'b0);
    test_angle(1, 12'h013, 0, 0, 1'b1, 1'b1, 1'b0);
    test_done(1, 12'h013, 0, 1'b1);
    test_no_angle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
